// File: rtl/vga_pkg.sv
// Shared VGA definitions: RGB444 pixel type, 3-bit palette, 640x480@60 timing.
package vga_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Default 640x480@60 raster (25.175 MHz pixel rate)
    localparam int unsigned VGA_H_VIS  = 640;
    localparam int unsigned VGA_H_FP   = 16;
    localparam int unsigned VGA_H_SYNC = 96;
    localparam int unsigned VGA_H_BP   = 48;
    localparam int unsigned VGA_V_VIS  = 480;
    localparam int unsigned VGA_V_FP   = 10;
    localparam int unsigned VGA_V_SYNC = 2;
    localparam int unsigned VGA_V_BP   = 33;
    localparam bit          VGA_H_POL  = 1'b0;
    localparam bit          VGA_V_POL  = 1'b0;

    // Index -> {R,G,B}: black, blue, brown, cyan, red, magenta, yellow, white
    localparam rgb444_t VGA_PALETTE [8] = '{
        12'h000, 12'h00F, 12'h841, 12'h088,
        12'hF00, 12'h808, 12'hFF0, 12'hFFF
    };

endpackage

// File: rtl/vga_palette.sv
// Combinational 3-bit palette index to RGB444 lookup.
module vga_palette
    import vga_pkg::*;
(
    input  logic [2:0] i_idx,
    output rgb444_t    o_rgb
);

    // Pure table lookup, no state
    always_comb begin
        o_rgb = VGA_PALETTE[i_idx];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with pixel-enable strobe and a 3-stage
// pipeline: counters/decode -> region flags + palette index -> RGB/sync out.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VIS  = VGA_H_VIS,
    parameter int unsigned H_FP   = VGA_H_FP,
    parameter int unsigned H_SYNC = VGA_H_SYNC,
    parameter int unsigned H_BP   = VGA_H_BP,
    parameter int unsigned V_VIS  = VGA_V_VIS,
    parameter int unsigned V_FP   = VGA_V_FP,
    parameter int unsigned V_SYNC = VGA_V_SYNC,
    parameter int unsigned V_BP   = VGA_V_BP,
    parameter bit          H_POL  = VGA_H_POL,
    parameter bit          V_POL  = VGA_V_POL,
    parameter int unsigned CW     = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    input  logic [2:0]    color_idx,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic [3:0]    R,
    output logic [3:0]    G,
    output logic [3:0]    B,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VEND = CW'(H_VIS);
    localparam logic [CW-1:0] V_VEND = CW'(V_VIS);
    localparam logic [CW-1:0] H_SBEG = CW'(H_VIS + H_FP);
    localparam logic [CW-1:0] H_SEND = CW'(H_VIS + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SBEG = CW'(V_VIS + V_FP);
    localparam logic [CW-1:0] V_SEND = CW'(V_VIS + V_FP + V_SYNC);

    logic [CW-1:0] r_hcount;
    logic [CW-1:0] r_vcount;
    logic          w_vis;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_col0;
    logic          w_org;

    logic          r_s1_valid;
    logic          r_s1_vis;
    logic          r_s1_hs;
    logic          r_s1_vs;
    logic          r_s1_col0;
    logic          r_s1_org;
    logic [2:0]    r_s1_idx;
    rgb444_t       w_rgb;

    rgb444_t       r_rgb;
    logic          r_de;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_line_start;
    logic          r_frame_start;

    // Stage 0: raster column/line counters, advanced only on pix_en
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (pix_en) begin
            if (r_hcount == H_LAST) begin
                r_hcount <= '0;
                r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
            end else begin
                r_hcount <= r_hcount + 1'b1;
            end
        end
    end

    // Stage 0: region decode; vertical sync uses the line number only
    always_comb begin
        w_vis    = (r_hcount < H_VEND) && (r_vcount < V_VEND);
        w_hs_act = (r_hcount >= H_SBEG) && (r_hcount < H_SEND);
        w_vs_act = (r_vcount >= V_SBEG) && (r_vcount < V_SEND);
        w_col0   = (r_hcount == '0);
        w_org    = (r_hcount == '0) && (r_vcount == '0);
    end

    // Stage 1: delay region flags and capture the source's palette index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_vis   <= 1'b0;
            r_s1_hs    <= 1'b0;
            r_s1_vs    <= 1'b0;
            r_s1_col0  <= 1'b0;
            r_s1_org   <= 1'b0;
            r_s1_idx   <= '0;
        end else if (pix_en) begin
            r_s1_valid <= 1'b1;
            r_s1_vis   <= w_vis;
            r_s1_hs    <= w_hs_act;
            r_s1_vs    <= w_vs_act;
            r_s1_col0  <= w_col0;
            r_s1_org   <= w_org;
            r_s1_idx   <= color_idx;
        end
    end

    vga_palette u_palette (
        .i_idx (r_s1_idx),
        .o_rgb (w_rgb)
    );

    // Stage 2: registered outputs; markers self-clear on the next clk so
    // they stay one clk wide even when pix_en is sparse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rgb         <= '0;
            r_de          <= 1'b0;
            r_hsync       <= ~H_POL;
            r_vsync       <= ~V_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (pix_en && r_s1_valid) begin
                r_rgb         <= r_s1_vis ? w_rgb : '0;
                r_de          <= r_s1_vis;
                r_hsync       <= r_s1_hs ~^ H_POL;
                r_vsync       <= r_s1_vs ~^ V_POL;
                r_line_start  <= r_s1_col0;
                r_frame_start <= r_s1_org;
            end
        end
    end

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign R           = r_rgb.r;
    assign G           = r_rgb.g;
    assign B           = r_rgb.b;
    assign de          = r_de;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: default 640x480 instance and a tiny 8x6 raster
// instance, both checked every clk against a closed-form raster model.
module tb_vga_timing_gen;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb;
        bit hp, vp;
    } tim_t;

    typedef struct {
        int          h;
        int          v;
        logic [2:0]  ci;
        logic [11:0] rgb;
        bit          de;
        bit          ls;
        bit          fs;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-timing instance
    logic        rst_a, en_a;
    logic [2:0]  ci_a;
    logic [10:0] hc_a, vc_a;
    logic [3:0]  r_a, g_a, b_a;
    logic        hs_a, vs_a, de_a, ls_a, fs_a;

    // Small-timing instance
    logic        rst_b, en_b;
    logic [2:0]  ci_b;
    logic [3:0]  hc_b, vc_b;
    logic [3:0]  r_b, g_b, b_b;
    logic        hs_b, vs_b, de_b, ls_b, fs_b;

    vga_timing_gen #(.CW(11)) dut_a (
        .clk(clk), .reset(rst_a), .pix_en(en_a), .color_idx(ci_a),
        .hcount(hc_a), .vcount(vc_a), .R(r_a), .G(g_a), .B(b_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .CW(4)
    ) dut_b (
        .clk(clk), .reset(rst_b), .pix_en(en_b), .color_idx(ci_b),
        .hcount(hc_b), .vcount(vc_b), .R(r_b), .G(g_b), .B(b_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    logic [38:0] act_a, act_b;
    assign act_a = {hc_a, vc_a, r_a, g_a, b_a, hs_a, vs_a, de_a, ls_a, fs_a};
    assign act_b = {7'b0, hc_b, 7'b0, vc_b, r_b, g_b, b_b, hs_b, vs_b, de_b, ls_b, fs_b};

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   na     = 0;
    int   nb     = 0;
    int   qa[$];
    int   qb[$];
    tim_t ta, tbt;
    vec_t vecs[9];

    int   t_ls[$], t_hf[$], t_hr[$];
    bit   prev_hs_a = 1'b1;
    bit   prev_ls_a = 1'b0;
    int   wide_ls   = 0;

    function automatic logic [11:0] pal(logic [2:0] i);
        case (i)
            3'd0: return 12'h000;
            3'd1: return 12'h00F;
            3'd2: return 12'h841;
            3'd3: return 12'h088;
            3'd4: return 12'hF00;
            3'd5: return 12'h808;
            3'd6: return 12'hFF0;
            default: return 12'hFFF;
        endcase
    endfunction

    // Expected outputs after n counted pix_en edges; col is the index the
    // source supplied for the pixel now at the output
    function automatic logic [38:0] model(tim_t t, int n, bit edge_en, int col);
        int ht, vt, p, h, v;
        logic [11:0] rgb;
        logic hsy, vsy, vis, ls, fs;
        ht = t.hv + t.hf + t.hs + t.hb;
        vt = t.vv + t.vf + t.vs + t.vb;
        if (n < 2) begin
            rgb = '0; hsy = ~t.hp; vsy = ~t.vp; vis = 1'b0; ls = 1'b0; fs = 1'b0;
        end else begin
            p   = n - 2;
            h   = p % ht;
            v   = (p / ht) % vt;
            vis = (h < t.hv) && (v < t.vv);
            rgb = vis ? pal(3'(col)) : 12'h000;
            hsy = (h >= t.hv + t.hf && h < t.hv + t.hf + t.hs) ? t.hp : ~t.hp;
            vsy = (v >= t.vv + t.vf && v < t.vv + t.vf + t.vs) ? t.vp : ~t.vp;
            ls  = edge_en && (h == 0);
            fs  = edge_en && (h == 0) && (v == 0);
        end
        return {11'(n % ht), 11'((n / ht) % vt), rgb, hsy, vsy, vis, ls, fs};
    endfunction

    task automatic check(string nm, logic [38:0] act, logic [38:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_int(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // One clk: drive at negedge, account edge at posedge, check at negedge
    task automatic step(bit ea, logic [2:0] ca, bit eb, logic [2:0] cb);
        bit ga, gb;
        en_a = ea; ci_a = ca; en_b = eb; ci_b = cb;
        @(posedge clk);
        ga = ea && rst_a;
        gb = eb && rst_b;
        if (ga) begin na++; qa.push_back(int'(ca)); end
        if (gb) begin nb++; qb.push_back(int'(cb)); end
        @(negedge clk);
        cyc++;
        check("dut_a", act_a, model(ta, na, ga, (na >= 2) ? qa[na-2] : 0));
        check("dut_b", act_b, model(tbt, nb, gb, (nb >= 2) ? qb[nb-2] : 0));
        if (ls_a) t_ls.push_back(cyc);
        if (prev_hs_a && !hs_a) t_hf.push_back(cyc);
        if (!prev_hs_a && hs_a) t_hr.push_back(cyc);
        if (prev_ls_a && ls_a) wide_ls++;
        prev_hs_a = hs_a;
        prev_ls_a = ls_a;
    endtask

    function automatic bit en_of(int mode, int i);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            4:       return (i % 4) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run(int k, int ma, int mb);
        for (int i = 0; i < k; i++)
            step(en_of(ma, i), 3'($urandom_range(0, 7)), en_of(mb, i), 3'($urandom_range(0, 7)));
    endtask

    task automatic reset_a();
        rst_a = 1'b0; na = 0; qa.delete();
        step(1'b1, 3'd0, 1'b0, 3'd0);
        step(1'b1, 3'd0, 1'b0, 3'd0);
        rst_a = 1'b1;
    endtask

    task automatic reset_b();
        rst_b = 1'b0; nb = 0; qb.delete();
        step(1'b0, 3'd0, 1'b1, 3'd0);
        step(1'b0, 3'd0, 1'b1, 3'd0);
        rst_b = 1'b1;
    endtask

    task automatic clear_meas();
        t_ls.delete(); t_hf.delete(); t_hr.delete();
        prev_hs_a = hs_a; prev_ls_a = ls_a; wide_ls = 0;
    endtask

    task automatic line_meas(string tag, int sp);
        check_int({tag, "_hs_offset"}, (t_ls.size() > 0 && t_hf.size() > 0) ? t_hf[0] - t_ls[0] : -1, 656 * sp);
        check_int({tag, "_hs_width"}, (t_hf.size() > 0 && t_hr.size() > 0) ? t_hr[0] - t_hf[0] : -1, 96 * sp);
        check_int({tag, "_ls_period"}, (t_ls.size() > 1) ? t_ls[1] - t_ls[0] : -1, 800 * sp);
    endtask

    initial begin
        int  lim, fs_at, per;
        logic [7:0] hmask;
        logic [5:0] vmask;

        ta  = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
        tbt = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};

        vecs[0] = '{0,   0, 3'd4, 12'hF00, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{639, 0, 3'd6, 12'hFF0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{640, 0, 3'd7, 12'h000, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1,   0, 3'd2, 12'h841, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{3,   0, 3'd3, 12'h088, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{0,   1, 3'd5, 12'h808, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{10,  1, 3'd1, 12'h00F, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{700, 1, 3'd7, 12'h000, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{2,   0, 3'd0, 12'h000, 1'b1, 1'b0, 1'b0};

        rst_a = 1'b0; rst_b = 1'b0;
        en_a = 1'b0; en_b = 1'b0; ci_a = '0; ci_b = '0;
        @(negedge clk);
        check("reset_a", act_a, model(ta, 0, 1'b0, 0));
        check("reset_b", act_b, model(tbt, 0, 1'b0, 0));
        step(1'b1, 3'd0, 1'b1, 3'd0);
        rst_a = 1'b1; rst_b = 1'b1;

        // Continuous pix_en: line timing
        clear_meas();
        run(1700, 1, 0);
        line_meas("cont", 1);

        // 1-in-4 pix_en: stretched timing, single-clk markers
        reset_a();
        clear_meas();
        run(6600, 4, 0);
        line_meas("sparse", 4);
        check_int("sparse_ls_width", wide_ls, 0);

        // Palette vectors at chosen coordinates
        foreach (vecs[i]) begin
            reset_a();
            lim = 0;
            while (na < vecs[i].v * 800 + vecs[i].h && lim < 4000) begin
                step(1'b1, 3'($urandom_range(0, 7)), 1'b0, 3'd0);
                lim++;
            end
            step(1'b1, vecs[i].ci, 1'b0, 3'd0);
            step(1'b1, 3'($urandom_range(0, 7)), 1'b0, 3'd0);
            check($sformatf("vec%0d", i), {24'd0, r_a, g_a, b_a, de_a, ls_a, fs_a},
                  {24'd0, vecs[i].rgb, vecs[i].de, vecs[i].ls, vecs[i].fs});
        end

        // Asynchronous reset mid-line at (300,2) with white on screen
        reset_a();
        while (na < 2 * 800 + 300) step(1'b1, 3'd7, 1'b0, 3'd0);
        check_int("pre_reset_hcount", int'(hc_a), 300);
        rst_a = 1'b0;
        #1;
        check("async_reset", act_a, {11'd0, 11'd0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        na = 0; qa.delete();
        step(1'b1, 3'd0, 1'b0, 3'd0);
        rst_a = 1'b1;
        fs_at = -1;
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 3'($urandom_range(0, 7)), 1'b0, 3'd0);
            if (fs_a && fs_at < 0) fs_at = k;
        end
        check_int("first_fs_after_reset", fs_at, 2);

        // Small raster: random pix_en, then exact frame shape
        reset_b();
        run(400, 99, 99);
        reset_b();
        lim = 0;
        while (!fs_b && lim < 10) begin
            step(1'b0, 3'd0, 1'b1, 3'($urandom_range(0, 7)));
            lim++;
        end
        check_int("small_fs_seen", int'(fs_b), 1);
        hmask = '0; vmask = '0; per = 0;
        for (int j = 0; j < 49; j++) begin
            if (j > 0) step(1'b0, 3'd0, 1'b1, 3'($urandom_range(0, 7)));
            if (j < 8) hmask[j] = hs_b;
            if (j < 48 && (j % 8) == 0) vmask[j / 8] = vs_b;
            if (j > 0 && fs_b && per == 0) per = j;
        end
        check_int("small_hsync_cols", int'(hmask), 8'b0110_0000);
        check_int("small_vsync_lines", int'(vmask), 6'b01_0000);
        check_int("small_frame_period", per, 48);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
